// File: rtl/pad_ctrl_pkg.sv
// pad_ctrl_pkg: shared pad mode encoding and defaults for the GPIO pad controller
package pad_ctrl_pkg;
  typedef enum logic [1:0] {
    PAD_MODE_IN   = 2'b00,
    PAD_MODE_PP   = 2'b01,
    PAD_MODE_OD   = 2'b10,
    PAD_MODE_RSVD = 2'b11
  } pad_mode_e;
  localparam int SYNC_STAGES_DEFAULT = 2;
endpackage

// File: rtl/pad_in_filter.sv
// pad_in_filter: synchronises, glitch-filters and edge-detects the asynchronous pad value
module pad_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              pad,
  input  logic              blank,
  input  logic [FILT_W-1:0] filt_len,
  output logic              in_val,
  output logic              rise,
  output logic              fall
);
  logic [SYNC_STAGES-1:0] sync;
  logic [FILT_W-1:0] cnt, lm1;
  logic s, hit;
  assign s = sync[SYNC_STAGES-1];
  assign lm1 = (filt_len == '0) ? '0 : filt_len - 1'b1;
  // >= so that shrinking filt_len mid-count commits on the next differing sample
  assign hit = (s != in_val) && (cnt >= lm1);
  always_ff @(posedge clk) begin
    if (rst) begin
      sync   <= '0;
      cnt    <= '0;
      in_val <= 1'b0;
      rise   <= 1'b0;
      fall   <= 1'b0;
    end else begin
      sync   <= {sync[SYNC_STAGES-2:0], pad};
      cnt    <= (s == in_val || hit) ? '0 : cnt + 1'b1;
      in_val <= hit ? s : in_val;
      rise   <= hit & s & ~blank;
      fall   <= hit & ~s & ~blank;
    end
  end
endmodule

// File: rtl/pad_gpio_ctrl.sv
// pad_gpio_ctrl: drives one bidirectional pad from a mode config and reads its value back
module pad_gpio_ctrl
  import pad_ctrl_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT,
  parameter int FILT_W = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [1:0]        mode_i,
  input  logic              out_val_i,
  input  logic              pull_en_i,
  input  logic [FILT_W-1:0] filt_len_i,
  output logic              pad_oen_o,
  output logic              pad_i_o,
  output logic              pad_pen_o,
  input  logic              pad_o_i,
  output logic              in_val_o,
  output logic              rise_o,
  output logic              fall_o
);
  localparam int BW = $clog2(SYNC_STAGES + (1 << FILT_W) + 1) + 1;
  pad_mode_e mode, mode_q;
  logic started, load;
  logic [BW-1:0] blank_cnt, blank_len;
  assign mode = pad_mode_e'(mode_i);
  assign load = ~started | (mode != mode_q);
  assign blank_len = BW'(SYNC_STAGES + 1) + BW'(filt_len_i) + BW'(filt_len_i == '0);
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      pad_oen_o <= 1'b1;
      pad_i_o   <= 1'b0;
      pad_pen_o <= 1'b1;
      mode_q    <= PAD_MODE_IN;
      started   <= 1'b0;
      blank_cnt <= '0;
    end else begin
      pad_oen_o <= (mode == PAD_MODE_PP) ? 1'b0 : (mode == PAD_MODE_OD) ? out_val_i : 1'b1;
      pad_i_o   <= (mode == PAD_MODE_PP) ? out_val_i : 1'b0;
      pad_pen_o <= ~pull_en_i;
      mode_q    <= mode;
      started   <= 1'b1;
      blank_cnt <= load ? blank_len : (blank_cnt != '0) ? blank_cnt - 1'b1 : '0;
    end
  end
  pad_in_filter #(.SYNC_STAGES(SYNC_STAGES), .FILT_W(FILT_W)) u_filt (
    .clk(clk_i),
    .rst(rst_i),
    .pad(pad_o_i),
    .blank(blank_cnt != '0),
    .filt_len(filt_len_i),
    .in_val(in_val_o),
    .rise(rise_o),
    .fall(fall_o)
  );
endmodule

// File: tb/tb_pad_gpio_ctrl.sv
// tb_pad_gpio_ctrl: directed self-checking bench for pad_gpio_ctrl with a simple pad model
module tb_pad_gpio_ctrl;
  logic clk = 1'b0, rst = 1'b1;
  logic [1:0] mode = 2'b00;
  logic out_val = 1'b0, pull_en = 1'b0, ext = 1'b1;
  logic [3:0] filt_len = 4'd1;
  logic pad_oen, pad_i, pad_pen, pad_o, in_val, rise, fall;
  int checks = 0, errors = 0;
  int n_rise, n_fall;

  // Pad cell: driven by pad_i when enabled, otherwise floats to the external/pull level
  assign pad_o = pad_oen ? ext : pad_i;

  pad_gpio_ctrl #(.SYNC_STAGES(2), .FILT_W(4)) dut (
    .clk_i(clk), .rst_i(rst), .mode_i(mode), .out_val_i(out_val), .pull_en_i(pull_en),
    .filt_len_i(filt_len), .pad_oen_o(pad_oen), .pad_i_o(pad_i), .pad_pen_o(pad_pen),
    .pad_o_i(pad_o), .in_val_o(in_val), .rise_o(rise), .fall_o(fall)
  );

  always #5 clk = ~clk;

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      n_rise += int'(rise);
      n_fall += int'(fall);
    end
  endtask

  task automatic chk(input string name, input logic got, input logic exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b", name, got, exp);
    end
  endtask

  task automatic chk_cnt(input string name, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  task automatic test_reset;
    rst = 1'b1; ext = 1'b1; mode = 2'b00; filt_len = 4'd1; pull_en = 1'b0;
    tick(3);
    chk("rst_oen", pad_oen, 1'b1);
    chk("rst_pad_i", pad_i, 1'b0);
    chk("rst_pen", pad_pen, 1'b1);
    chk("rst_in_val", in_val, 1'b0);
    chk("rst_rise", rise, 1'b0);
    chk("rst_fall", fall, 1'b0);
    rst = 1'b0; n_rise = 0; n_fall = 0;
    tick(2);
    chk("rel_in_val_early", in_val, 1'b0);
    tick(2);
    chk("rel_in_val", in_val, 1'b1);
    tick(8);
    chk_cnt("rel_rise_masked", n_rise, 0);
  endtask

  task automatic test_filter;
    filt_len = 4'd3; ext = 1'b0;
    tick(12);
    chk("filt_low", in_val, 1'b0);
    ext = 1'b1; n_rise = 0;
    tick(4);
    chk("filt_lat4_val", in_val, 1'b0);
    chk("filt_lat4_rise", rise, 1'b0);
    tick(1);
    chk("filt_lat5_val", in_val, 1'b1);
    chk("filt_lat5_rise", rise, 1'b1);
    tick(1);
    chk("filt_lat6_rise", rise, 1'b0);
    chk_cnt("filt_rise_count", n_rise, 1);
    ext = 1'b0;
    tick(10);
    chk("filt_back_low", in_val, 1'b0);
  endtask

  task automatic test_glitch;
    filt_len = 4'd4; n_rise = 0;
    ext = 1'b1; tick(2); ext = 1'b0;
    tick(8);
    chk("glitch2_val", in_val, 1'b0);
    ext = 1'b1; tick(3); ext = 1'b0;
    tick(8);
    chk("glitch3_val", in_val, 1'b0);
    chk_cnt("glitch_rise", n_rise, 0);
  endtask

  task automatic test_pp;
    filt_len = 4'd2; mode = 2'b01; out_val = 1'b0;
    tick(12);
    chk("pp_oen", pad_oen, 1'b0);
    chk("pp_pad_i0", pad_i, 1'b0);
    chk("pp_in0", in_val, 1'b0);
    out_val = 1'b1; n_rise = 0; n_fall = 0;
    tick(1);
    chk("pp_pad_i1", pad_i, 1'b1);
    tick(3);
    chk("pp_r4_val", in_val, 1'b0);
    tick(1);
    chk("pp_r5_val", in_val, 1'b1);
    chk("pp_r5_rise", rise, 1'b1);
    tick(3);
    out_val = 1'b0;
    tick(1);
    chk("pp_pad_i_back", pad_i, 1'b0);
    tick(4);
    chk("pp_f5_val", in_val, 1'b0);
    chk("pp_f5_fall", fall, 1'b1);
    tick(3);
    chk_cnt("pp_rise_count", n_rise, 1);
    chk_cnt("pp_fall_count", n_fall, 1);
  endtask

  task automatic test_od;
    mode = 2'b10; out_val = 1'b1; pull_en = 1'b1; ext = 1'b1;
    tick(1);
    chk("od_oen_rel", pad_oen, 1'b1);
    chk("od_pad_i_rel", pad_i, 1'b0);
    chk("od_pen", pad_pen, 1'b0);
    tick(11);
    chk("od_in_high", in_val, 1'b1);
    out_val = 1'b0; n_fall = 0;
    tick(1);
    chk("od_oen_drv", pad_oen, 1'b0);
    chk("od_pad_i_drv", pad_i, 1'b0);
    tick(8);
    chk("od_readback", in_val, 1'b0);
    chk_cnt("od_fall_count", n_fall, 1);
  endtask

  task automatic test_turnaround;
    mode = 2'b01; out_val = 1'b1;
    tick(12);
    chk("ta_pp_high", in_val, 1'b1);
    ext = 1'b0; mode = 2'b00; n_rise = 0; n_fall = 0;
    tick(12);
    chk("ta_in_follow", in_val, 1'b0);
    chk_cnt("ta_no_fall", n_fall, 0);
    chk_cnt("ta_no_rise", n_rise, 0);
  endtask

  task automatic test_reset_mid;
    filt_len = 4'd4; pull_en = 1'b1; ext = 1'b1;
    tick(3);
    chk("mid_pen_on", pad_pen, 1'b0);
    rst = 1'b1;
    tick(1);
    chk("mid_oen", pad_oen, 1'b1);
    chk("mid_pad_i", pad_i, 1'b0);
    chk("mid_pen", pad_pen, 1'b1);
    chk("mid_in_val", in_val, 1'b0);
    chk("mid_rise", rise, 1'b0);
    ext = 1'b0; rst = 1'b0;
    tick(12);
    chk("mid_after_val", in_val, 1'b0);
  endtask

  initial begin
    n_rise = 0; n_fall = 0;
    test_reset();
    test_filter();
    test_glitch();
    test_pp();
    test_od();
    test_turnaround();
    test_reset_mid();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/pad_gpio_ctrl.md
Name: pad_gpio_ctrl

Overview:
Core-side controller for one bidirectional pad of the pad_functional_pu/pd family. It drives the pad's OEN/I/PEN pins from a mode configuration and samples the pad's O pin back into the clock domain. It synchronises, glitch-filters and edge-detects the pad value. One instance sits per GPIO between the register file and the pad cell.

Parameters:
SYNC_STAGES, 2, flop stages in the input synchroniser (legal range >= 2).
FILT_W, 4, width of the glitch-filter length and counter.

Ports:
clk_i  in  1  clock.
rst_i  in  1  reset; synchronous, active-high.
mode_i  in  2  pad mode, encoded as pad_mode_e.
out_val_i  in  1  value to drive.
pull_en_i  in  1  1 = enable the pad pull resistor.
filt_len_i  in  FILT_W  consecutive stable samples required before in_val_o changes.
pad_oen_o  out  1  pad output enable, active-low.
pad_i_o  out  1  pad data in.
pad_pen_o  out  1  pad pull enable, active-low.
pad_o_i  in  1  pad data out; asynchronous.
in_val_o  out  1  filtered, synchronised pad value.
rise_o  out  1  one-cycle pulse on a filtered 0->1 transition.
fall_o  out  1  one-cycle pulse on a filtered 1->0 transition.

Behaviour:
- Only clk_i is used. Every flop resets synchronously while rst_i=1.
- Reset values:
  - pad_oen_o=1, pad_i_o=0, pad_pen_o=1 (pad floating, pull off).
  - in_val_o=0, rise_o=0, fall_o=0.
  - Synchroniser flops, filter counter and blank counter all 0.
- Drive path: registered, so outputs reflect inputs with 1-cycle latency.
  - PAD_MODE_IN (00) and reserved 11: pad_oen_o=1, pad_i_o=0.
  - PAD_MODE_PP (01): pad_oen_o=0, pad_i_o=out_val_i.
  - PAD_MODE_OD (10): pad_i_o=0, pad_oen_o=out_val_i. Drives low for 0, releases for 1.
  - pad_pen_o = ~pull_en_i in every mode.
- Synchroniser: pad_o_i passes through SYNC_STAGES flops; the last stage output is s.
- Glitch filter: holds state f (which is in_val_o) and counter cnt.
  - Let L = max(filt_len_i, 1).
  - s==f: cnt<=0.
  - s!=f and cnt==L-1: f<=s, cnt<=0.
  - s!=f otherwise: cnt<=cnt+1.
  - Net effect: s must differ from f for L consecutive cycles. A glitch shorter than L leaves f unchanged and cnt returns to 0.
  - filt_len_i changing mid-count: the new value applies immediately. If cnt is already >= new L-1, f updates on the next cycle in which s!=f.
- Latency:
  - Take edge k as the first clock edge that samples the new pad_o_i level.
  - in_val_o shows the new value after edge k+SYNC_STAGES-1+L, i.e. SYNC_STAGES+L edges total.
- Edges:
  - rise_o/fall_o are registered and assert in the same cycle in_val_o first shows the new value.
  - They last exactly 1 cycle and are never asserted together.
- Blanking:
  - blank_cnt loads SYNC_STAGES+L+1 on the first cycle after reset release. It also loads on any cycle where mode_i differs from its registered copy.
  - blank_cnt decrements to 0.
  - While blank_cnt!=0, rise_o/fall_o are forced to 0, but f still updates. This suppresses the spurious post-reset or turnaround edge.
  - A mode change during blanking reloads the counter.
- Readback: in PP and OD modes the input path still samples the pad. Example: OD driving 0 with an external high gives in_val_o=0.
- Reset mid-operation: a pending filter count is discarded. Outputs return to reset values on the edge where rst_i=1.

Decomposition:
- Package pad_ctrl_pkg:
  - typedef enum logic [1:0] pad_mode_e {PAD_MODE_IN=2'b00, PAD_MODE_PP=2'b01, PAD_MODE_OD=2'b10, PAD_MODE_RSVD=2'b11}.
  - Localparam SYNC_STAGES_DEFAULT=2.
- Sub-module pad_in_filter holds the synchroniser, glitch filter and edge register. It takes parameters SYNC_STAGES and FILT_W and a blank input.
- The top level holds the drive registers, the mode register and the blank counter.

Test Plan:
1. Reset with pad_o_i=1 (pull-up), then release -> in_val_o=1 after SYNC_STAGES+1+1 edges; rise_o stays 0 because blanking masks it.
2. Mode IN, filt_len_i=3, pad_o_i 0->1 held -> in_val_o=1 exactly 5 edges after the first sampling edge; rise_o=1 for 1 cycle in that same cycle.
3. filt_len_i=4, 2-cycle glitch 0->1->0 on pad_o_i -> in_val_o stays 0, no rise_o, cnt returns to 0.
4. Mode PP with out_val_i toggling 0/1 -> pad_oen_o=0 and pad_i_o follows with 1-cycle lag; in_val_o loops back with SYNC_STAGES+L latency; fall_o/rise_o pulse once per toggle.
5. Mode OD, out_val_i=1 then 0 -> pad_oen_o=1 then 0 with pad_i_o=0 throughout; pull_en_i=1 gives pad_pen_o=0.
6. Switch PP->IN while the pad pull drives the opposite level -> in_val_o follows, but no edge pulse within SYNC_STAGES+L+1 cycles. Assert rst_i mid-filter-count -> all outputs at reset values next edge.
